tc_avg_filter: RTL
==================

# tc_avg_filter

Moving-average filter between the thermocouple calculator and the SPI slave readback register. It accepts each converted temperature as a one-cycle strobe and keeps the last 2^DEPTH_LOG2 samples in a ring buffer. It holds a running sum and presents the floor average to the SPI slave's output word. Its purpose is to suppress ADC code noise without a divider.

## Interface
- DATA_W, 20: temperature sample width (matches calculator output).
- DEPTH_LOG2, 3: log2 of window length; DEPTH = 2^DEPTH_LOG2; legal range 1..5.
- i_clk  in  1  rising-edge clock, the system 10 MHz clock.
- i_rst_n  in  1  reset. Synchronous, active-low; sampled on i_clk.
- i_stb  in  1  one-cycle strobe: i_temp is valid this cycle (driven by calculator done).
- i_temp  in  DATA_W  unsigned temperature sample.
- i_clear  in  1  one-cycle request to discard the window and return to EMPTY.
- o_avg  out  DATA_W  registered window average; held between updates.
- o_stb  out  1  one-cycle pulse: o_avg has just updated.
- o_primed  out  1  high once at least one sample has been taken since reset/clear.

## Operation
- State register with two states: EMPTY (no sample since reset/clear) and RUN.
- Ring buffer: DEPTH × DATA_W registers, write pointer wr_ptr (DEPTH_LOG2 bits, wraps modulo DEPTH), running sum of DATA_W+DEPTH_LOG2 bits (cannot overflow).
- EMPTY, i_stb=1: prefill. All DEPTH entries <= i_temp; sum <= i_temp << DEPTH_LOG2; wr_ptr <= 0; state -> RUN; o_primed <= 1.
- RUN, i_stb=1: sum <= sum + i_temp − buf[wr_ptr]; buf[wr_ptr] <= i_temp; wr_ptr <= wr_ptr+1 (wraps DEPTH−1 -> 0).
- Average: o_avg <= sum >> DEPTH_LOG2 (floor, unsigned). No rounding.
- i_clear=1 with i_stb=0: state -> EMPTY; sum, wr_ptr, o_primed <= 0. o_avg holds its last value and no o_stb is issued. Buffer contents are don't-care.
- i_clear=1 with i_stb=1: clear has priority, and the same sample is then taken as the EMPTY prefill sample. Net effect: the window equals DEPTH copies of i_temp and an o_stb follows.
- i_stb=0, i_clear=0: no state change.
- Back-to-back strobes, including every cycle, are all accepted. There is no backpressure and no sample is dropped.

## Timing
- Reset (i_rst_n=0 at an edge): state=EMPTY; o_avg=0, o_stb=0, o_primed=0; sum=0, wr_ptr=0. Reset overrides i_stb/i_clear in the same cycle.
- Latency is 2 edges. At edge k (i_stb=1) the buffer, sum and pointer update. At edge k+1, o_avg is loaded from the updated sum and o_stb goes high for exactly one cycle.
- With strobes on consecutive cycles, o_stb is high on consecutive cycles. Each o_avg reflects the window ending at its own sample.
- o_primed rises at edge k, which is 1 cycle before the first o_stb.
- A reset asserted between edge k and edge k+1 cancels the pending o_stb.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package tc_pkg holds TEMP_W=20, the state encoding (EMPTY=1'b0, RUN=1'b1) and the default window log2.
- A sub-module tc_ring (ring-buffer storage with prefill-all and write-at-pointer/read-oldest ports) is natural. Sum, state and output logic stay in tc_avg_filter.
- Top-level integration: i_stb = calc_done, i_temp = current_temp. The SPI slave word takes o_avg >> 2 in place of the raw temperature.

## Test plan
- Reset, then single i_stb with i_temp=1000 -> o_primed=1 after edge k; o_stb one cycle at edge k+1 with o_avg=1000.
- Primed at 1000, then i_temp=1008 -> sum=8008, o_avg=1001. Next i_temp=1000 -> o_avg=1001; sum is still 8008 (the oldest 1000 replaced by 1000).
- Primed at 1000, then eight strobes of 2000 on consecutive cycles -> o_stb high 8 consecutive cycles. o_avg sequence is 1125, 1250, 1375, 1500, 1625, 1750, 1875, 2000. wr_ptr wraps to 0.
- Nine strobes of 20'hFFFFF -> o_avg=20'hFFFFF with no overflow; sum=23'h7FFFF8.
- Window of 2000, then i_clear and i_stb(500) in the same cycle -> o_avg=500 at the next edge. Separately, i_clear alone -> o_primed=0, o_avg held at 2000, no o_stb.
- i_rst_n=0 on the cycle after an accepted strobe -> no o_stb, o_avg=0, o_primed=0. The next strobe of 300 prefills and gives o_avg=300.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared definitions for the thermocouple datapath: sample width,
// averaging-filter state encoding and the default window size.
package tc_pkg;

    localparam int unsigned TEMP_W             = 20;
    localparam int unsigned DEFAULT_DEPTH_LOG2 = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } avg_state_e;

endpackage : tc_pkg

// File: rtl/tc_ring.sv
// Ring-buffer storage for the moving-average window. Supports loading every
// entry at once (prefill) or writing one entry at the pointer. The read port
// returns the entry at the pointer, which is the oldest sample in the window.
module tc_ring
    import tc_pkg::*;
#(
    parameter int unsigned DATA_W     = TEMP_W,
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  prefill_i,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] ptr_i,
    input  logic [DATA_W-1:0]     data_i,
    output logic [DATA_W-1:0]     oldest_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Window storage: reset to zero, prefill all entries, or overwrite the oldest.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (prefill_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= data_i;
            end
        end else if (wr_en_i) begin
            mem_q[ptr_i] <= data_i;
        end else begin
            mem_q[ptr_i] <= mem_q[ptr_i];
        end
    end

    assign oldest_o = mem_q[ptr_i];

endmodule : tc_ring

// File: rtl/tc_avg_filter.sv
// Moving-average filter over the last 2^DEPTH_LOG2 temperature samples.
// A running sum avoids re-adding the window; the average is a plain right
// shift, so no divider is needed. The first sample after reset/clear fills
// the whole window so the output is meaningful immediately.
module tc_avg_filter
    import tc_pkg::*;
#(
    parameter int unsigned DATA_W     = TEMP_W,
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stb,
    input  logic [DATA_W-1:0] i_temp,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_avg,
    output logic              o_stb,
    output logic              o_primed
);

    localparam int unsigned SUM_W = DATA_W + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    avg_state_e            state_q, state_d;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic                  primed_q, primed_d;
    logic                  pend_q, pend_d;
    logic [DATA_W-1:0]     avg_q, avg_d;
    logic                  stb_q, stb_d;

    logic                  prefill_s;
    logic                  run_wr_s;
    logic [DATA_W-1:0]     oldest_s;

    // A strobe while empty, or together with a clear, restarts the window.
    assign prefill_s = i_stb && ((state_q == ST_EMPTY) || i_clear);
    assign run_wr_s  = i_stb && !prefill_s;

    tc_ring #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ring (
        .clk_i     (i_clk),
        .rst_n_i   (i_rst_n),
        .prefill_i (prefill_s),
        .wr_en_i   (run_wr_s),
        .ptr_i     (wr_ptr_q),
        .data_i    (i_temp),
        .oldest_o  (oldest_s)
    );

    // Window bookkeeping: state, running sum, write pointer and primed flag.
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        wr_ptr_d = wr_ptr_q;
        primed_d = primed_q;
        pend_d   = 1'b0;
        if (prefill_s) begin
            state_d  = ST_RUN;
            sum_d    = SUM_W'(i_temp) << DEPTH_LOG2;
            wr_ptr_d = {DEPTH_LOG2{1'b0}};
            primed_d = 1'b1;
            pend_d   = 1'b1;
        end else if (run_wr_s) begin
            // The outgoing sample is part of sum_q, so this never underflows.
            sum_d    = sum_q + SUM_W'(i_temp) - SUM_W'(oldest_s);
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            pend_d   = 1'b1;
        end else if (i_clear) begin
            state_d  = ST_EMPTY;
            sum_d    = {SUM_W{1'b0}};
            wr_ptr_d = {DEPTH_LOG2{1'b0}};
            primed_d = 1'b0;
        end else begin
            state_d  = state_q;
        end
    end

    // Output stage: one edge after a sample is taken, publish the new average.
    always_comb begin
        avg_d = avg_q;
        stb_d = 1'b0;
        if (pend_q) begin
            avg_d = DATA_W'(sum_q >> DEPTH_LOG2);
            stb_d = 1'b1;
        end else begin
            avg_d = avg_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_EMPTY;
            sum_q    <= {SUM_W{1'b0}};
            wr_ptr_q <= {DEPTH_LOG2{1'b0}};
            primed_q <= 1'b0;
            pend_q   <= 1'b0;
            avg_q    <= {DATA_W{1'b0}};
            stb_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            wr_ptr_q <= wr_ptr_d;
            primed_q <= primed_d;
            pend_q   <= pend_d;
            avg_q    <= avg_d;
            stb_q    <= stb_d;
        end
    end

    assign o_avg    = avg_q;
    assign o_stb    = stb_q;
    assign o_primed = primed_q;

endmodule : tc_avg_filter
